// File: rtl/ps2_rx_decoder.sv
// Host-side PS/2 receiver: conditions the PS/2 lines, deframes 11-bit frames,
// buffers good bytes in a show-ahead FIFO and assembles scancodes into key events.
module ps2_rx_decoder #(
    parameter int FILTER    = 4,
    parameter int TIMEOUT   = 4096,
    parameter int FIFO_BITS = 3
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        rx_rd,
    output logic [7:0]  rx_dout,
    output logic        rx_empty,
    output logic        rx_overflow,
    output logic        parity_err,
    output logic        frame_err,
    output logic [10:0] key
);

    localparam int DEPTH = 1 << FIFO_BITS;
    localparam int FCW   = $clog2(FILTER + 1);
    localparam int TCW   = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    localparam logic [FCW-1:0]     FILT_LAST = FCW'(FILTER - 1);
    localparam logic [TCW-1:0]     TO_LAST   = TCW'(TIMEOUT - 1);
    localparam logic [FIFO_BITS-1:0] PTR_ONE = {{(FIFO_BITS-1){1'b0}}, 1'b1};
    localparam logic [FIFO_BITS:0] CNT_ONE   = {{FIFO_BITS{1'b0}}, 1'b1};
    localparam logic [FIFO_BITS:0] CNT_FULL  = (FIFO_BITS+1)'(DEPTH);

    // Odd-parity check over 8 data bits plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] data_bits, input logic par_bit);
        odd_parity_ok = ^{data_bits, par_bit};
    endfunction

    logic           clk_meta_r;
    logic           clk_sync_r;
    logic           data_meta_r;
    logic           data_sync_r;
    logic           filt_clk_r;
    logic [FCW-1:0] filt_cnt_r;
    logic           sample_s;

    logic [1:0]     state_r;
    logic [2:0]     bit_cnt_r;
    logic [7:0]     shift_r;
    logic           par_ok_r;
    logic [TCW-1:0] to_cnt_r;
    logic           byte_valid_r;
    logic [7:0]     byte_r;
    logic           parity_err_r;
    logic           frame_err_r;

    logic [7:0]           mem_r [DEPTH];
    logic [FIFO_BITS-1:0] wr_ptr_r;
    logic [FIFO_BITS-1:0] rd_ptr_r;
    logic [FIFO_BITS:0]   count_r;
    logic                 overflow_r;
    logic                 full_s;
    logic                 rd_en_s;
    logic                 wr_en_s;
    logic                 empty_s;

    logic        ext_r;
    logic        rel_r;
    logic [2:0]  skip_cnt_r;
    logic [10:0] key_r;

    // Two-flop synchronisers for the asynchronous PS/2 lines.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            clk_meta_r  <= 1'b1;
            clk_sync_r  <= 1'b1;
            data_meta_r <= 1'b1;
            data_sync_r <= 1'b1;
        end else begin
            clk_meta_r  <= ps2_clk;
            clk_sync_r  <= clk_meta_r;
            data_meta_r <= ps2_data;
            data_sync_r <= data_meta_r;
        end
    end

    // Glitch filter: accept a new clock level only after FILTER stable cycles.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            filt_clk_r <= 1'b1;
            filt_cnt_r <= '0;
        end else if (clk_sync_r == filt_clk_r) begin
            filt_cnt_r <= '0;
        end else if (filt_cnt_r == FILT_LAST) begin
            filt_clk_r <= clk_sync_r;
            filt_cnt_r <= '0;
        end else begin
            filt_cnt_r <= filt_cnt_r + {{(FCW-1){1'b0}}, 1'b1};
        end
    end

    // The filtered clock falls in exactly the cycle this term is high.
    assign sample_s = filt_clk_r & ~clk_sync_r & (filt_cnt_r == FILT_LAST);

    // Frame receiver with mid-frame timeout; error and good-byte outputs are one-cycle pulses.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            bit_cnt_r    <= 3'd0;
            shift_r      <= 8'h00;
            par_ok_r     <= 1'b0;
            to_cnt_r     <= '0;
            byte_valid_r <= 1'b0;
            byte_r       <= 8'h00;
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            byte_valid_r <= 1'b0;
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
            if (sample_s) begin
                to_cnt_r <= '0;
                case (state_r)
                    ST_IDLE: begin
                        if (!data_sync_r) begin
                            state_r   <= ST_DATA;
                            bit_cnt_r <= 3'd0;
                        end else begin
                            state_r   <= ST_IDLE;
                        end
                    end
                    ST_DATA: begin
                        shift_r   <= {data_sync_r, shift_r[7:1]};
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            state_r <= ST_PARITY;
                        end else begin
                            state_r <= ST_DATA;
                        end
                    end
                    ST_PARITY: begin
                        par_ok_r <= odd_parity_ok(shift_r, data_sync_r);
                        state_r  <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (!data_sync_r) begin
                            frame_err_r  <= 1'b1;
                        end else if (par_ok_r) begin
                            byte_valid_r <= 1'b1;
                            byte_r       <= shift_r;
                        end else begin
                            parity_err_r <= 1'b1;
                        end
                        state_r <= ST_IDLE;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end else if (state_r != ST_IDLE) begin
                if (to_cnt_r == TO_LAST) begin
                    frame_err_r <= 1'b1;
                    state_r     <= ST_IDLE;
                    to_cnt_r    <= '0;
                end else begin
                    to_cnt_r    <= to_cnt_r + {{(TCW-1){1'b0}}, 1'b1};
                end
            end else begin
                to_cnt_r <= '0;
            end
        end
    end

    assign empty_s = (count_r == '0);
    assign full_s  = (count_r == CNT_FULL);
    assign rd_en_s = rx_rd & ~empty_s;
    // A simultaneous pop frees the slot, so a write on full still succeeds.
    assign wr_en_s = byte_valid_r & (~full_s | rd_en_s);

    // FIFO storage; contents need no reset because rx_dout is gated by empty.
    always_ff @(posedge clk_sys) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= byte_r;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // FIFO pointers, occupancy and overflow pulse.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= byte_valid_r & full_s & ~rd_en_s;
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Scancode assembler: prefix flags, Pause skip window and fake-shift suppression.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            ext_r      <= 1'b0;
            rel_r      <= 1'b0;
            skip_cnt_r <= 3'd0;
            key_r      <= 11'h000;
        end else if (parity_err_r || frame_err_r) begin
            ext_r      <= 1'b0;
            rel_r      <= 1'b0;
            skip_cnt_r <= 3'd0;
        end else if (byte_valid_r) begin
            if (skip_cnt_r != 3'd0) begin
                skip_cnt_r <= skip_cnt_r - 3'd1;
                if (skip_cnt_r == 3'd1) begin
                    key_r <= {~key_r[10], 10'h377};
                    ext_r <= 1'b0;
                    rel_r <= 1'b0;
                end else begin
                    key_r <= key_r;
                end
            end else begin
                case (byte_r)
                    8'hE0: ext_r      <= 1'b1;
                    8'hF0: rel_r      <= 1'b1;
                    8'hE1: skip_cnt_r <= 3'd7;
                    default: begin
                        if (!(ext_r && (byte_r == 8'h12))) begin
                            key_r <= {~key_r[10], ~rel_r, ext_r, byte_r};
                        end else begin
                            key_r <= key_r;
                        end
                        ext_r <= 1'b0;
                        rel_r <= 1'b0;
                    end
                endcase
            end
        end else begin
            key_r <= key_r;
        end
    end

    assign rx_empty    = empty_s;
    assign rx_dout     = empty_s ? 8'h00 : mem_r[rd_ptr_r];
    assign rx_overflow = overflow_r;
    assign parity_err  = parity_err_r;
    assign frame_err   = frame_err_r;
    assign key         = key_r;

endmodule

// File: tb/tb_ps2_rx_decoder.sv
// Self-checking bench for ps2_rx_decoder: PS/2 frames are driven serially and
// expected FIFO bytes and key events are queued as a scoreboard.
module tb_ps2_rx_decoder;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic        rx_rd = 1'b0;
    logic [7:0]  rx_dout;
    logic        rx_empty;
    logic        rx_overflow;
    logic        parity_err;
    logic        frame_err;
    logic [10:0] key;

    int checks = 0;
    int errors = 0;

    int pe_cnt = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    logic [10:0] key_prev = 11'h000;
    logic [10:0] obs_key_q[$];
    int obs_rd = 0;

    logic [7:0]  exp_byte_q[$];
    logic [10:0] exp_key_q[$];
    logic        exp_tog = 1'b0;

    ps2_rx_decoder dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .rx_rd       (rx_rd),
        .rx_dout     (rx_dout),
        .rx_empty    (rx_empty),
        .rx_overflow (rx_overflow),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .key         (key)
    );

    always #5 clk_sys = ~clk_sys;

    // Monitor: count pulses and record every key change.
    always @(negedge clk_sys) begin
        if (reset_n) begin
            if (parity_err)  pe_cnt <= pe_cnt + 1;
            if (frame_err)   fe_cnt <= fe_cnt + 1;
            if (rx_overflow) ov_cnt <= ov_cnt + 1;
            if (key !== key_prev) obs_key_q.push_back(key);
            key_prev <= key;
        end else begin
            key_prev <= 11'h000;
        end
    end

    task automatic push_key(input logic [9:0] v);
        exp_tog = ~exp_tog;
        exp_key_q.push_back({exp_tog, v});
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n, input int hp);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            repeat (hp / 2) @(posedge clk_sys);
            ps2_clk = 1'b0;
            repeat (hp) @(posedge clk_sys);
            ps2_clk = 1'b1;
            repeat (hp / 2) @(posedge clk_sys);
        end
        ps2_data = 1'b1;
        repeat (20) @(posedge clk_sys);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int hp);
        logic par;
        par = ~(^b) ^ bad_par;
        send_bits({~bad_stop, par, b, 1'b0}, 11, hp);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (5) @(posedge clk_sys);
        reset_n = 1'b1;
        @(negedge clk_sys);
        checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", rx_empty); end
        checks++; if (rx_dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h want 00", rx_dout); end
        checks++; if (key !== 11'h000) begin errors++; $display("FAIL reset_key got %h want 000", key); end
        checks++; if ({parity_err, frame_err, rx_overflow} !== 3'b000) begin
            errors++; $display("FAIL reset_pulses got %b want 000", {parity_err, frame_err, rx_overflow});
        end
    endtask

    task automatic test_single_byte;
        logic [7:0] eb;
        send_frame(8'h1C, 1'b0, 1'b0, 200);
        exp_byte_q.push_back(8'h1C);
        push_key(10'h21C);
        @(negedge clk_sys);
        checks++; if (key !== 11'h61C) begin errors++; $display("FAIL single_key got %h want 61C", key); end
        while (exp_key_q.size() > 0) begin
            logic [10:0] ek;
            ek = exp_key_q.pop_front();
            checks++;
            if (obs_rd >= obs_key_q.size()) begin errors++; $display("FAIL single_keyev got none want %h", ek); end
            else if (obs_key_q[obs_rd] !== ek) begin errors++; $display("FAIL single_keyev got %h want %h", obs_key_q[obs_rd], ek); end
            obs_rd++;
        end
        while (exp_byte_q.size() > 0) begin
            eb = exp_byte_q.pop_front();
            checks++;
            if (rx_empty !== 1'b0 || rx_dout !== eb) begin
                errors++; $display("FAIL single_fifo got %h empty=%b want %h", rx_dout, rx_empty, eb);
            end
            rx_rd = 1'b1; @(negedge clk_sys); rx_rd = 1'b0;
        end
        checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL single_drained got %b want 1", rx_empty); end
    endtask

    task automatic test_sequences;
        logic [7:0] seq [7] = '{8'hF0, 8'h1C, 8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
        logic [7:0] eb;
        int n0;
        n0 = obs_key_q.size();
        foreach (seq[i]) begin
            send_frame(seq[i], 1'b0, 1'b0, 80);
            exp_byte_q.push_back(seq[i]);
        end
        push_key(10'h01C);
        push_key(10'h375);
        push_key(10'h175);
        @(negedge clk_sys);
        checks++; if (obs_key_q.size() - n0 !== 3) begin errors++; $display("FAIL seq_keycount got %0d want 3", obs_key_q.size() - n0); end
        while (exp_key_q.size() > 0) begin
            logic [10:0] ek;
            ek = exp_key_q.pop_front();
            checks++;
            if (obs_rd >= obs_key_q.size()) begin errors++; $display("FAIL seq_keyev got none want %h", ek); end
            else if (obs_key_q[obs_rd] !== ek) begin errors++; $display("FAIL seq_keyev got %h want %h", obs_key_q[obs_rd], ek); end
            obs_rd++;
        end
        while (exp_byte_q.size() > 0) begin
            eb = exp_byte_q.pop_front();
            checks++;
            if (rx_empty !== 1'b0 || rx_dout !== eb) begin
                errors++; $display("FAIL seq_fifo got %h empty=%b want %h", rx_dout, rx_empty, eb);
            end
            rx_rd = 1'b1; @(negedge clk_sys); rx_rd = 1'b0;
        end
        checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL seq_drained got %b want 1", rx_empty); end
    endtask

    task automatic test_errors;
        int pe0, fe0, k0;
        pe0 = pe_cnt; fe0 = fe_cnt; k0 = obs_key_q.size();
        send_frame(8'h00, 1'b1, 1'b0, 80);
        @(negedge clk_sys);
        checks++; if (pe_cnt - pe0 !== 1) begin errors++; $display("FAIL parity_pe got %0d want 1", pe_cnt - pe0); end
        checks++; if (fe_cnt - fe0 !== 0) begin errors++; $display("FAIL parity_fe got %0d want 0", fe_cnt - fe0); end
        checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL parity_empty got %b want 1", rx_empty); end
        pe0 = pe_cnt; fe0 = fe_cnt;
        send_frame(8'h00, 1'b0, 1'b1, 80);
        @(negedge clk_sys);
        checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL stop_fe got %0d want 1", fe_cnt - fe0); end
        checks++; if (pe_cnt - pe0 !== 0) begin errors++; $display("FAIL stop_pe got %0d want 0", pe_cnt - pe0); end
        checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL stop_empty got %b want 1", rx_empty); end
        checks++; if (obs_key_q.size() !== k0) begin errors++; $display("FAIL err_key got %0d events want 0", obs_key_q.size() - k0); end
    endtask

    task automatic test_overflow;
        logic [7:0] b;
        logic [7:0] eb;
        int ov0;
        ov0 = ov_cnt;
        for (int i = 1; i <= 10; i++) begin
            b = 8'(i);
            send_frame(b, 1'b0, 1'b0, 80);
            if (i <= 8) exp_byte_q.push_back(b);
            push_key({2'b10, b});
        end
        @(negedge clk_sys);
        checks++; if (ov_cnt - ov0 !== 2) begin errors++; $display("FAIL ovf_count got %0d want 2", ov_cnt - ov0); end
        while (exp_key_q.size() > 0) begin
            logic [10:0] ek;
            ek = exp_key_q.pop_front();
            checks++;
            if (obs_rd >= obs_key_q.size()) begin errors++; $display("FAIL ovf_keyev got none want %h", ek); end
            else if (obs_key_q[obs_rd] !== ek) begin errors++; $display("FAIL ovf_keyev got %h want %h", obs_key_q[obs_rd], ek); end
            obs_rd++;
        end
        while (exp_byte_q.size() > 0) begin
            eb = exp_byte_q.pop_front();
            checks++;
            if (rx_empty !== 1'b0 || rx_dout !== eb) begin
                errors++; $display("FAIL ovf_fifo got %h empty=%b want %h", rx_dout, rx_empty, eb);
            end
            rx_rd = 1'b1; @(negedge clk_sys); rx_rd = 1'b0;
        end
        checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL ovf_drained got %b want 1", rx_empty); end
        rx_rd = 1'b1; @(negedge clk_sys); rx_rd = 1'b0;
        checks++; if (rx_empty !== 1'b1 || rx_dout !== 8'h00) begin
            errors++; $display("FAIL ovf_rd_empty got %h empty=%b want 00 empty=1", rx_dout, rx_empty);
        end
    endtask

    task automatic test_timeout;
        int fe0, pe0;
        fe0 = fe_cnt; pe0 = pe_cnt;
        send_bits(11'h008, 4, 80);
        repeat (5000) @(posedge clk_sys);
        @(negedge clk_sys);
        checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL timeout_fe got %0d want 1", fe_cnt - fe0); end
        checks++; if (pe_cnt - pe0 !== 0) begin errors++; $display("FAIL timeout_pe got %0d want 0", pe_cnt - pe0); end
        checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL timeout_empty got %b want 1", rx_empty); end
        send_frame(8'h1C, 1'b0, 1'b0, 80);
        push_key(10'h21C);
        @(negedge clk_sys);
        checks++; if (rx_empty !== 1'b0 || rx_dout !== 8'h1C) begin
            errors++; $display("FAIL after_timeout_fifo got %h empty=%b want 1C", rx_dout, rx_empty);
        end
        rx_rd = 1'b1; @(negedge clk_sys); rx_rd = 1'b0;
        while (exp_key_q.size() > 0) begin
            logic [10:0] ek;
            ek = exp_key_q.pop_front();
            checks++;
            if (obs_rd >= obs_key_q.size()) begin errors++; $display("FAIL timeout_keyev got none want %h", ek); end
            else if (obs_key_q[obs_rd] !== ek) begin errors++; $display("FAIL timeout_keyev got %h want %h", obs_key_q[obs_rd], ek); end
            obs_rd++;
        end
    endtask

    task automatic test_pause_and_glitch;
        logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        logic [7:0] eb;
        int n0, fe0;
        n0 = obs_key_q.size();
        foreach (seq[i]) begin
            send_frame(seq[i], 1'b0, 1'b0, 80);
            exp_byte_q.push_back(seq[i]);
        end
        push_key(10'h377);
        @(negedge clk_sys);
        checks++; if (obs_key_q.size() - n0 !== 1) begin errors++; $display("FAIL pause_count got %0d want 1", obs_key_q.size() - n0); end
        while (exp_key_q.size() > 0) begin
            logic [10:0] ek;
            ek = exp_key_q.pop_front();
            checks++;
            if (obs_rd >= obs_key_q.size()) begin errors++; $display("FAIL pause_keyev got none want %h", ek); end
            else if (obs_key_q[obs_rd] !== ek) begin errors++; $display("FAIL pause_keyev got %h want %h", obs_key_q[obs_rd], ek); end
            obs_rd++;
        end
        while (exp_byte_q.size() > 0) begin
            eb = exp_byte_q.pop_front();
            checks++;
            if (rx_empty !== 1'b0 || rx_dout !== eb) begin
                errors++; $display("FAIL pause_fifo got %h empty=%b want %h", rx_dout, rx_empty, eb);
            end
            rx_rd = 1'b1; @(negedge clk_sys); rx_rd = 1'b0;
        end
        // A sample caught here would start a frame on data=0 and later time out.
        fe0 = fe_cnt; n0 = obs_key_q.size();
        ps2_data = 1'b0;
        @(posedge clk_sys); ps2_clk = 1'b0;
        repeat (2) @(posedge clk_sys);
        ps2_clk = 1'b1;
        repeat (5000) @(posedge clk_sys);
        ps2_data = 1'b1;
        @(negedge clk_sys);
        checks++; if (fe_cnt - fe0 !== 0) begin errors++; $display("FAIL glitch_fe got %0d want 0", fe_cnt - fe0); end
        checks++; if (rx_empty !== 1'b1 || obs_key_q.size() !== n0) begin
            errors++; $display("FAIL glitch_quiet got empty=%b keyevents=%0d want empty=1 keyevents=0", rx_empty, obs_key_q.size() - n0);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_sequences();
        test_errors();
        test_overflow();
        test_timeout();
        test_pause_and_glitch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
